// File: rtl/p_hit_arb.sv
// Round-robin scheduler sharing one p_hit unit between two ray sources.
// Jobs are tagged with the requester id; in-order results are steered back by tag.
module p_hit_arb #(
    parameter int D_BITS    = 32,
    parameter int TAG_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [1:0]                    req_empty,
    output logic [1:0]                    req_rd_en,
    input  logic [3*D_BITS-1:0]           req0_normal,
    input  logic [3*D_BITS-1:0]           req0_v0,
    input  logic [3*D_BITS-1:0]           req0_origin,
    input  logic [3*D_BITS-1:0]           req0_dir,
    input  logic [3*D_BITS-1:0]           req1_normal,
    input  logic [3*D_BITS-1:0]           req1_v0,
    input  logic [3*D_BITS-1:0]           req1_origin,
    input  logic [3*D_BITS-1:0]           req1_dir,
    output logic [3*D_BITS-1:0]           ph_tri_normal,
    output logic [3*D_BITS-1:0]           ph_v0,
    output logic [3*D_BITS-1:0]           ph_origin,
    output logic [3*D_BITS-1:0]           ph_dir,
    input  logic [3:0]                    ph_in_full,
    output logic [3:0]                    ph_in_wr_en,
    input  logic [3*D_BITS-1:0]           ph_out,
    input  logic [3*D_BITS-1:0]           ph_v0_out,
    input  logic                          ph_out_empty,
    output logic                          ph_out_rd_en,
    output logic [3*D_BITS-1:0]           rsp_out,
    output logic [3*D_BITS-1:0]           rsp_v0,
    output logic [1:0]                    rsp_wr_en,
    input  logic [1:0]                    rsp_full,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err
);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam logic [AW:0] TAG_FULL_CNT = (AW+1)'(TAG_DEPTH);

    logic [TAG_DEPTH-1:0] tag_mem;
    logic [AW-1:0]        tag_wr_ptr;
    logic [AW-1:0]        tag_rd_ptr;
    logic [AW:0]          tag_cnt;
    logic                 tag_full;
    logic                 tag_empty;
    logic                 tag_head;
    logic                 last_grant;
    logic [1:0]           elig;
    logic                 grant;
    logic                 issue;
    logic                 ret;
    logic                 sel1;
    logic [1:0]           vld_p1;
    logic [3*D_BITS-1:0]  rsp_out_p1;
    logic [3*D_BITS-1:0]  rsp_v0_p1;

    assign tag_full  = (tag_cnt == TAG_FULL_CNT);
    assign tag_empty = (tag_cnt == '0);
    assign tag_head  = tag_mem[tag_rd_ptr];
    assign elig      = ~req_empty;

    always_comb begin
        grant = 1'b0;
        case (elig)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

    // Stage p0: combinational issue and return decisions
    assign issue        = !reset && (ph_in_full == 4'b0000) && !tag_full && (elig != 2'b00);
    assign ret          = !reset && !ph_out_empty && !tag_empty && !rsp_full[tag_head];
    assign req_rd_en    = issue ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign ph_in_wr_en  = {4{issue}};
    assign ph_out_rd_en = ret;
    assign sel1         = issue && grant;

    // Idle cycles leave the requester-0 words on the bus
    assign ph_tri_normal = sel1 ? req1_normal : req0_normal;
    assign ph_v0         = sel1 ? req1_v0     : req0_v0;
    assign ph_origin     = sel1 ? req1_origin : req0_origin;
    assign ph_dir        = sel1 ? req1_dir    : req0_dir;

    always_ff @(posedge clock) begin
        if (issue)
            tag_mem[tag_wr_ptr] <= grant;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_cnt    <= '0;
            last_grant <= 1'b1;
            err        <= 1'b0;
            vld_p1     <= 2'b00;
            rsp_out_p1 <= '0;
            rsp_v0_p1  <= '0;
        end else begin
            if (issue) begin
                tag_wr_ptr <= tag_wr_ptr + AW'(1);
                last_grant <= grant;
            end
            if (ret)
                tag_rd_ptr <= tag_rd_ptr + AW'(1);
            case ({issue, ret})
                2'b10:   tag_cnt <= tag_cnt + (AW+1)'(1);
                2'b01:   tag_cnt <= tag_cnt - (AW+1)'(1);
                default: tag_cnt <= tag_cnt;
            endcase
            if (!ph_out_empty && tag_empty)
                err <= 1'b1;
            // Stage p1: registered result toward the owning requester
            vld_p1 <= ret ? (tag_head ? 2'b10 : 2'b01) : 2'b00;
            if (ret) begin
                rsp_out_p1 <= ph_out;
                rsp_v0_p1  <= ph_v0_out;
            end
        end
    end

    assign rsp_wr_en   = vld_p1;
    assign rsp_out     = rsp_out_p1;
    assign rsp_v0      = rsp_v0_p1;
    assign outstanding = tag_cnt;

endmodule

// File: tb/tb_p_hit_arb.sv
// Bench for p_hit_arb: queue-based requester FIFOs and a zero-latency p_hit stub,
// with grant and response scoreboards checked by a negedge monitor.
module tb_p_hit_arb;
    localparam int D  = 32;
    localparam int TD = 4;
    localparam int W3 = 3*D;
    localparam int CW = 384;

    typedef struct packed { logic [W3-1:0] n, v, o, d; } job_t;
    typedef struct packed { logic [W3-1:0] pt, v0; } res_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0] req_empty, req_rd_en, rsp_wr_en, rsp_full;
    logic [W3-1:0] req0_normal, req0_v0, req0_origin, req0_dir;
    logic [W3-1:0] req1_normal, req1_v0, req1_origin, req1_dir;
    logic [W3-1:0] ph_tri_normal, ph_v0, ph_origin, ph_dir;
    logic [3:0] ph_in_full, ph_in_wr_en;
    logic [W3-1:0] ph_out, ph_v0_out, rsp_out, rsp_v0;
    logic ph_out_empty, ph_out_rd_en, err;
    logic [$clog2(TD):0] outstanding;

    p_hit_arb #(.D_BITS(D), .TAG_DEPTH(TD)) dut (
        .clock(clock), .reset(reset),
        .req_empty(req_empty), .req_rd_en(req_rd_en),
        .req0_normal(req0_normal), .req0_v0(req0_v0), .req0_origin(req0_origin), .req0_dir(req0_dir),
        .req1_normal(req1_normal), .req1_v0(req1_v0), .req1_origin(req1_origin), .req1_dir(req1_dir),
        .ph_tri_normal(ph_tri_normal), .ph_v0(ph_v0), .ph_origin(ph_origin), .ph_dir(ph_dir),
        .ph_in_full(ph_in_full), .ph_in_wr_en(ph_in_wr_en),
        .ph_out(ph_out), .ph_v0_out(ph_v0_out), .ph_out_empty(ph_out_empty), .ph_out_rd_en(ph_out_rd_en),
        .rsp_out(rsp_out), .rsp_v0(rsp_v0), .rsp_wr_en(rsp_wr_en), .rsp_full(rsp_full),
        .outstanding(outstanding), .err(err)
    );

    always #5 clock = ~clock;

    job_t rq0[$], rq1[$];
    res_t phq[$], exp0[$], exp1[$];
    int exp_g[$];
    logic [1:0] exp_s[$];
    logic hold_ph = 1'b0;
    logic force_ne = 1'b0;
    int rel_cnt = 0;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got unexpected event, expected none", name);
    endtask

    task automatic refresh;
        job_t j0, j1;
        res_t hr;
        req_empty = {rq1.size() == 0, rq0.size() == 0};
        j0 = (rq0.size() > 0) ? rq0[0] : '0;
        j1 = (rq1.size() > 0) ? rq1[0] : '0;
        {req0_normal, req0_v0, req0_origin, req0_dir} = j0;
        {req1_normal, req1_v0, req1_origin, req1_dir} = j1;
        ph_out_empty = !force_ne && (phq.size() == 0 || (hold_ph && rel_cnt == 0));
        hr = (phq.size() > 0) ? phq[0] : '1;
        ph_out = hr.pt;
        ph_v0_out = hr.v0;
    endtask

    // Ray along -z from z=5 hits plane z=vz (normal +z) at (ox, oy, vz)
    task automatic push_ray(input int r, input logic [D-1:0] ox, input logic [D-1:0] oy, input logic [D-1:0] vz);
        job_t j;
        res_t e;
        j.n = {32'h0, 32'h0, 32'h0001_0000};
        j.v = {32'h0, 32'h0, vz};
        j.o = {ox, oy, 32'h0005_0000};
        j.d = {32'h0, 32'h0, 32'hFFFF_0000};
        e.pt = {ox, oy, vz};
        e.v0 = j.v;
        if (r == 0) begin rq0.push_back(j); exp0.push_back(e); end
        else        begin rq1.push_back(j); exp1.push_back(e); end
    endtask

    // p_hit stub and requester FIFO bookkeeping
    logic [1:0] rd_s;
    logic [3:0] wr_s;
    logic ord_s;
    logic [W3-1:0] o_s, v_s;
    res_t new_r;
    always begin
        @(posedge clock);
        rd_s = req_rd_en; wr_s = ph_in_wr_en; ord_s = ph_out_rd_en;
        o_s = ph_origin; v_s = ph_v0;
        #2;
        if (rd_s[0] && rq0.size() > 0) rq0.delete(0);
        if (rd_s[1] && rq1.size() > 0) rq1.delete(0);
        if (wr_s == 4'hF) begin
            new_r.pt = {o_s[W3-1:D], v_s[D-1:0]};
            new_r.v0 = v_s;
            phq.push_back(new_r);
        end
        if (ord_s && phq.size() > 0) begin
            phq.delete(0);
            if (rel_cnt > 0) rel_cnt--;
        end
        refresh();
    end

    job_t mon_j;
    always @(negedge clock) begin
        if (!reset) begin
            if (ph_in_wr_en != 4'h0) begin
                chk("wr_all", CW'(ph_in_wr_en), CW'(4'hF));
                chk("rd_onehot", CW'(req_rd_en == 2'b01 || req_rd_en == 2'b10), CW'(1'b1));
                if (exp_g.size() > 0) begin
                    chk("grant", CW'(req_rd_en[1]), CW'(exp_g[0]));
                    exp_g.delete(0);
                end else fail("grant_unexp");
                if (req_rd_en[1]) mon_j = (rq1.size() > 0) ? rq1[0] : '0;
                else              mon_j = (rq0.size() > 0) ? rq0[0] : '0;
                chk("ph_data", CW'({ph_tri_normal, ph_v0, ph_origin, ph_dir}), CW'(mon_j));
            end
            if (rsp_wr_en != 2'b00) begin
                if (exp_s.size() > 0) begin
                    chk("rsp_order", CW'(rsp_wr_en), CW'(exp_s[0]));
                    exp_s.delete(0);
                end
                if (rsp_wr_en == 2'b01) begin
                    if (exp0.size() > 0) begin
                        chk("rsp0", CW'({rsp_out, rsp_v0}), CW'(exp0[0]));
                        exp0.delete(0);
                    end else fail("rsp0_unexp");
                end else if (rsp_wr_en == 2'b10) begin
                    if (exp1.size() > 0) begin
                        chk("rsp1", CW'({rsp_out, rsp_v0}), CW'(exp1[0]));
                        exp1.delete(0);
                    end else fail("rsp1_unexp");
                end else fail("rsp_onehot");
            end
        end
    end

    task automatic drain(input int bound);
        int k = 0;
        while ((exp0.size() + exp1.size() + rq0.size() + rq1.size() != 0 || outstanding != 0) && k < bound) begin
            @(negedge clock);
            k++;
        end
        chk("drain_left", CW'(exp0.size() + exp1.size() + int'(outstanding)), CW'(0));
        chk("grants_left", CW'(exp_g.size() + exp_s.size()), CW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ph_in_full = 4'h0;
        rsp_full = 2'b00;
        refresh();
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_req_rd_en", CW'(req_rd_en), CW'(0));
        chk("rst_ph_in_wr_en", CW'(ph_in_wr_en), CW'(0));
        chk("rst_ph_out_rd_en", CW'(ph_out_rd_en), CW'(0));
        chk("rst_rsp_wr_en", CW'(rsp_wr_en), CW'(0));
        chk("rst_rsp_out", CW'(rsp_out), CW'(0));
        chk("rst_rsp_v0", CW'(rsp_v0), CW'(0));
        chk("rst_outstanding", CW'(outstanding), CW'(0));
        chk("rst_err", CW'(err), CW'(0));

        // single requester, issue right after reset release
        @(posedge clock); #1;
        reset = 1'b0;
        push_ray(0, 32'h0, 32'h0, 32'h0001_0000);
        push_ray(0, 32'h0, 32'h0, 32'h0002_0000);
        push_ray(0, 32'h0, 32'h0, 32'h0003_0000);
        exp_g = '{0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t1_issue", CW'(ph_in_wr_en), CW'(4'hF));
        end
        @(negedge clock);
        chk("t1_idle", CW'(ph_in_wr_en), CW'(4'h0));
        drain(30);

        // alternating grants from a fresh reset
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_ray(0, 32'h0001_0000 * i, 32'h0, 32'h0010_0000 + 32'h0001_0000 * i);
            push_ray(1, 32'h0001_0000 * i, 32'h0001_0000, 32'h0020_0000 + 32'h0001_0000 * i);
        end
        exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
        drain(60);

        // p_hit input back-pressure
        @(posedge clock); #1;
        ph_in_full = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            push_ray(0, 32'h0007_0000, 32'h0000_8000, 32'h0030_0000 + 32'h0001_0000 * i);
            push_ray(1, 32'hFFFF_0000, 32'h0003_0000, 32'h0040_0000 + 32'h0001_0000 * i);
        end
        exp_g = '{0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t3_hold_wr", CW'(ph_in_wr_en), CW'(4'h0));
            chk("t3_hold_rd", CW'(req_rd_en), CW'(2'b00));
        end
        @(posedge clock); #1 ph_in_full = 4'h0;
        @(negedge clock);
        chk("t3_resume_wr", CW'(ph_in_wr_en), CW'(4'hF));
        chk("t3_resume_rd", CW'(req_rd_en), CW'(2'b01));
        drain(60);

        // tag FIFO full with a stalled p_hit
        @(posedge clock); #1;
        hold_ph = 1'b1;
        for (int i = 0; i < 6; i++) push_ray(0, 32'h0, 32'h0002_0000, 32'h0050_0000 + 32'h0001_0000 * i);
        exp_g = '{0, 0, 0, 0, 0, 0};
        n = 0;
        repeat (8) begin
            @(negedge clock);
            if (ph_in_wr_en != 4'h0) n++;
        end
        chk("t4_issues", CW'(n), CW'(4));
        chk("t4_outstanding", CW'(outstanding), CW'(4));
        @(posedge clock); #1 rel_cnt = 1;
        n = 0;
        repeat (6) begin
            @(negedge clock);
            if (ph_in_wr_en != 4'h0) n++;
        end
        chk("t4_one_more", CW'(n), CW'(1));
        chk("t4_outstanding2", CW'(outstanding), CW'(4));
        @(posedge clock); #1 hold_ph = 1'b0;
        drain(60);

        // head-of-line blocking on a full requester-1 output
        @(posedge clock); #1;
        rsp_full = 2'b10;
        push_ray(1, 32'h0009_0000, 32'h0, 32'h0060_0000);
        push_ray(0, 32'h000A_0000, 32'h0, 32'h0070_0000);
        exp_g = '{1, 0};
        exp_s = '{2'b10, 2'b01};
        repeat (6) begin
            @(negedge clock);
            chk("t5_blocked_rd", CW'(ph_out_rd_en), CW'(1'b0));
            chk("t5_blocked_wr", CW'(rsp_wr_en), CW'(2'b00));
        end
        @(posedge clock); #1 rsp_full = 2'b00;
        drain(30);

        // orphan result sets err
        @(posedge clock); #1 force_ne = 1'b1;
        @(negedge clock);
        chk("t6_no_pop", CW'(ph_out_rd_en), CW'(1'b0));
        chk("t6_err_pre", CW'(err), CW'(1'b0));
        @(posedge clock); #1 force_ne = 1'b0;
        @(negedge clock);
        chk("t6_err_set", CW'(err), CW'(1'b1));

        // reset with jobs in flight
        @(posedge clock); #1;
        hold_ph = 1'b1;
        for (int i = 0; i < 3; i++) push_ray(1, 32'h0, 32'h0, 32'h0080_0000 + 32'h0001_0000 * i);
        exp_g = '{1, 1, 1};
        repeat (5) @(negedge clock);
        chk("t6_outstanding3", CW'(outstanding), CW'(3));
        chk("t6_err_sticky", CW'(err), CW'(1'b1));
        #1 reset = 1'b1;
        phq.delete();
        exp1.delete();
        #1;
        chk("t6_rst_outstanding", CW'(outstanding), CW'(0));
        chk("t6_rst_err", CW'(err), CW'(1'b0));
        chk("t6_rst_rsp_wr", CW'(rsp_wr_en), CW'(2'b00));
        @(posedge clock); #1;
        hold_ph = 1'b0;
        reset = 1'b0;
        push_ray(0, 32'h000B_0000, 32'h000C_0000, 32'h0090_0000);
        exp_g = '{0};
        drain(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
